seq_det_ctrl: RTL
=================

Name: seq_det_ctrl

Overview:
Frame controller that sequences a single-bit sequence-detector datapath (Moore/Mealy, overlapping/non-overlapping). Accepts parallel words over a valid/ready handshake and holds the detector in reset between words. Serialises each word MSB-first into the detector, then drains its output latency. Counts detector hits per word and returns a result word over a second valid/ready handshake.

Parameters:
WORD_W, 8, bits per input word; range 2..32.
CNT_W, 4, width of the hit counter; the counter saturates at 2^CNT_W-1.
LAT, 0, detector output latency in cycles (0 = Mealy, 1 = Moore); range 0..2.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset, synchronous, active-high.
in_valid  in  1  input word valid.
in_ready  out  1  controller can accept a word.
in_data  in  WORD_W  word to scan; bit WORD_W-1 is shifted first.
det_rst_n  out  1  active-low reset to the detector.
det_x  out  1  serial bit to the detector.
det_z  in  1  detector match output.
res_valid  out  1  result valid.
res_ready  in  1  result accepted.
res_count  out  CNT_W  number of hits in the word, saturating.
res_last_hit  out  1  a match ended on the word's final bit.
res_hitmap  out  WORD_W  per-bit match map (see Optional Feature).
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE. in_ready=1, res_valid=0, res_count=0, res_last_hit=0, res_hitmap=0, det_rst_n=0, det_x=0, busy=0.
  - Reset mid-operation discards the word in flight and any unread result.
- States: IDLE -> SHIFT -> DRAIN (skipped when LAT=0) -> REPORT -> IDLE.
- IDLE:
  - in_ready=1; det_rst_n=0 holds the detector in reset; det_x=0.
  - On in_valid&in_ready: latch in_data into the shift register, set bit index to 0, clear the counter, last-hit flag and hitmap, go to SHIFT.
- SHIFT, exactly WORD_W cycles:
  - det_rst_n=1; det_x = shift-register MSB; shift left one bit per cycle.
  - The detector's first clocked bit is its first post-reset bit.
- DRAIN, exactly LAT cycles: det_rst_n=1, det_x=0.
- Sampling rule:
  - Number the SHIFT and DRAIN cycles s=0..WORD_W+LAT-1.
  - det_z is sampled only when s>=LAT; the sample at cycle s belongs to input bit i=s-LAT.
  - When det_z=1: counter increments, saturating and never wrapping. If i=WORD_W-1, last_hit=1. Hitmap bit WORD_W-1-i is set, so hits align with in_data bit positions.
- REPORT:
  - res_valid=1; res_count, res_last_hit and res_hitmap are stable and held until res_ready=1 at a clk edge, then go to IDLE.
  - in_ready=0, det_rst_n=0.
  - A same-cycle new in_valid is not accepted; acceptance waits for the next cycle in IDLE.
- Latency: handshake edge at cycle 0 -> res_valid high from cycle WORD_W+LAT+1. Minimum issue interval is WORD_W+LAT+2 cycles with res_ready tied high.
- in_ready is 0 in SHIFT, DRAIN and REPORT; in_data is ignored there.
- Overlap vs non-overlap is decided solely by the attached detector; the controller counts what det_z reports.

Optional Feature:
- Macro: SEQ_DET_CTRL_HITMAP_EN.
- Defined: the hitmap register is implemented and res_hitmap reports it.
- Undefined: the hitmap register is removed and res_hitmap is tied to 0. The port list is identical in both builds.

Test Plan:
1. LAT=0, overlapping Mealy "1011" detector, in_data=8'b1011_0110 -> res_count=2, res_last_hit=0, res_hitmap=8'b0001_0010 (with macro), res_valid at cycle 9.
2. Same word with a non-overlapping Mealy "1011" detector -> res_count=1, res_hitmap=8'b0001_0000. Then in_data=8'b0000_1011 -> res_count=1, res_last_hit=1, res_hitmap=8'b0000_0001.
3. LAT=1, overlapping Moore "1011" detector, in_data=8'b0000_1011 -> res_count=1, res_last_hit=1 (hit captured in DRAIN), res_valid at cycle 10; det_rst_n low in IDLE and REPORT.
4. WORD_W=16, CNT_W=2, overlapping "1011", in_data=16'b1011_0110_1101_1011 -> 5 raw hits, res_count saturates at 3.
5. Hold res_ready=0 for 5 cycles in REPORT with in_valid=1 -> outputs stable, in_ready=0, word not accepted; after res_ready=1 the word is accepted the following cycle.
6. Assert rst for 1 cycle during SHIFT bit 4 -> next cycle IDLE, in_ready=1, det_rst_n=0, res_valid=0. A fresh word then scans correctly from bit 0.

Source files
------------

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: frame controller for a single-bit sequence detector.
// Accepts a word, resets the detector, shifts the word in MSB-first, drains
// the detector latency and reports a saturating hit count plus last-hit flag.
// Optional macro SEQ_DET_CTRL_HITMAP_EN keeps the per-bit hitmap register;
// without it res_hitmap is tied to zero (port list unchanged).
module seq_det_ctrl #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 4,
    parameter int LAT    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              det_rst_n,
    output logic              det_x,
    input  logic              det_z,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CNT_W-1:0]  res_count,
    output logic              res_last_hit,
    output logic [WORD_W-1:0] res_hitmap,
    output logic              busy
);

    localparam int SW = $clog2(WORD_W + LAT + 1);
    localparam logic [SW:0] LAT_X = (SW+1)'(LAT);

    typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, REPORT} state_t;

    state_t             state_q, state_d;
    logic [WORD_W-1:0]  sreg_q, sreg_d;
    logic [WORD_W-1:0]  mask_q, mask_d;   // one-hot: bit of in_data the next sample belongs to
    logic [SW-1:0]      s_q, s_d;         // SHIFT/DRAIN cycle number
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_q, last_d;
    logic [SW:0]        lag;
    logic               scan;
    logic               samp;
`ifdef SEQ_DET_CTRL_HITMAP_EN
    logic [WORD_W-1:0]  hit_q, hit_d;
`endif

    // Sign bit of s-LAT tells whether the detector output is valid yet.
    assign lag  = {1'b0, s_q} - LAT_X;
    assign scan = (state_q == SHIFT) || (state_q == DRAIN);
    assign samp = scan && !lag[SW];

    // Next-state, datapath updates and hit capture.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        mask_d  = mask_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
`ifdef SEQ_DET_CTRL_HITMAP_EN
        hit_d   = hit_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sreg_d  = in_data;
                    mask_d  = {1'b1, {(WORD_W-1){1'b0}}};
                    s_d     = '0;
                    cnt_d   = '0;
                    last_d  = 1'b0;
`ifdef SEQ_DET_CTRL_HITMAP_EN
                    hit_d   = '0;
`endif
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sreg_d = sreg_q << 1;
                s_d    = s_q + SW'(1);
                if (s_q == SW'(WORD_W - 1))
                    state_d = (LAT == 0) ? REPORT : DRAIN;
            end
            DRAIN: begin
                s_d = s_q + SW'(1);
                if (s_q == SW'(WORD_W + LAT - 1))
                    state_d = REPORT;
            end
            REPORT: begin
                if (res_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Each sample consumes one mask position; a hit is attributed to it.
        if (samp) begin
            mask_d = mask_q >> 1;
            if (det_z) begin
                if (cnt_q != {CNT_W{1'b1}})
                    cnt_d = cnt_q + CNT_W'(1);
                if (mask_q[0])
                    last_d = 1'b1;
`ifdef SEQ_DET_CTRL_HITMAP_EN
                hit_d = hit_q | mask_q;
`endif
            end
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            mask_q  <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
`ifdef SEQ_DET_CTRL_HITMAP_EN
            hit_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            mask_q  <= mask_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
`ifdef SEQ_DET_CTRL_HITMAP_EN
            hit_q   <= hit_d;
`endif
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign res_valid    = (state_q == REPORT);
    assign busy         = (state_q != IDLE);
    assign det_rst_n    = scan;
    assign det_x        = (state_q == SHIFT) && sreg_q[WORD_W-1];
    assign res_count    = cnt_q;
    assign res_last_hit = last_q;
`ifdef SEQ_DET_CTRL_HITMAP_EN
    assign res_hitmap   = hit_q;
`else
    assign res_hitmap   = '0;
`endif

endmodule
